// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - Pipelined segmented ripple-carry adder with valid/ready flow control
// Define PIPE_ADDER_SUB_EN to add the SUB port (X - Y mode).
module pipe_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Z,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             SUB,
`endif
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V
);

   localparam int STAGES = WIDTH / SEG;

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] cr;
   logic [WIDTH-1:0]  xr [STAGES];
   logic [WIDTH-1:0]  yr [STAGES];
   logic [WIDTH-1:0]  sr [STAGES];
   logic              v_r;

   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] c_in;
   logic [WIDTH-1:0]  x_in [STAGES];
   logic [WIDTH-1:0]  y_in [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];

   logic [STAGES-1:0] c_nx;
   logic [WIDTH-1:0]  s_nx [STAGES];
   logic              v_nx;

   logic [WIDTH-1:0]  y_eff;
   logic              z_eff;

   // Subtract folds into the add path: invert Y at entry and force carry-in.
`ifdef PIPE_ADDER_SUB_EN
   assign y_eff = SUB ? ~Y : Y;
   assign z_eff = SUB | Z;
`else
   assign y_eff = Y;
   assign z_eff = Z;
`endif

   // A stage may move unless it and every stage after it is full and the output is stalled.
   always_comb begin
      logic tail_full;
      tail_full = 1'b1;
      adv       = '0;
      for (int k = 0; k < STAGES; k++) begin
         tail_full = 1'b1;
         for (int j = k; j < STAGES; j++) begin
            tail_full = tail_full & vld[j];
         end
         adv[k] = !tail_full || OUT_READY;
      end
   end

   always_comb begin
      x_in[0] = X;
      y_in[0] = y_eff;
      s_in[0] = '0;
      c_in    = '0;
      v_in    = '0;
      c_in[0] = z_eff;
      v_in[0] = IN_VALID;
      for (int k = 1; k < STAGES; k++) begin
         x_in[k] = xr[k-1];
         y_in[k] = yr[k-1];
         s_in[k] = sr[k-1];
         c_in[k] = cr[k-1];
         v_in[k] = vld[k-1];
      end
   end

   always_comb begin
      logic [SEG:0] seg;
      seg  = '0;
      c_nx = '0;
      for (int k = 0; k < STAGES; k++) begin
         seg = {1'b0, x_in[k][k*SEG +: SEG]} + {1'b0, y_in[k][k*SEG +: SEG]}
             + {{SEG{1'b0}}, c_in[k]};
         s_nx[k]                = s_in[k];
         s_nx[k][k*SEG +: SEG]  = seg[SEG-1:0];
         c_nx[k]                = seg[SEG];
      end
      // Carry into the MSB recovered from the MSB sum bit.
      v_nx = x_in[STAGES-1][WIDTH-1] ^ y_in[STAGES-1][WIDTH-1]
           ^ s_nx[STAGES-1][WIDTH-1] ^ c_nx[STAGES-1];
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         vld <= '0;
         cr  <= '0;
         v_r <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            xr[k] <= '0;
            yr[k] <= '0;
            sr[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               vld[k] <= v_in[k];
            end
            if (adv[k] && v_in[k]) begin
               xr[k] <= x_in[k];
               yr[k] <= y_in[k];
               sr[k] <= s_nx[k];
               cr[k] <= c_nx[k];
            end
         end
         if (adv[STAGES-1] && v_in[STAGES-1]) begin
            v_r <= v_nx;
         end
      end
   end

   assign IN_READY  = adv[0];
   assign OUT_VALID = vld[STAGES-1];
   assign S         = sr[STAGES-1];
   assign C         = cr[STAGES-1];
   assign V         = v_r;

endmodule
